// File: rtl/fusion_pkg.sv
// Shared definitions for the bit-fusion sequencer: state encoding,
// per-mode pass count and mode legality.
package fusion_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the final pass for a mode: (num_banks >> mode) - 1.
    function automatic int pass_last(input int num_banks, input int mode);
        return (num_banks >> mode) - 1;
    endfunction

    function automatic logic mode_legal(input int mode, input int max_mode);
        return (mode < max_mode);
    endfunction

endpackage

// File: rtl/fusion_pass_cnt.sv
// Wrapping pass-address counter with a programmable last value; advances
// on each fired step and flags the first/last pass of an operand.
module fusion_pass_cnt #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] limit,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  first,
    output logic                  last,
    output logic                  wrap
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (en) begin
            addr <= last ? '0 : addr + ADDR_WIDTH'(1);
        end
    end

    assign first = (addr == '0);
    assign last  = (addr == limit);
    assign wrap  = en & last;

endmodule

// File: rtl/fusion_seq_ctrl.sv
// Sequencer for the spatial bit-fusion multiplier array: accepts a layer
// configuration and steps the shared mode/addr lines through every pass of
// every operand. Optional performance counters: FUSION_SEQ_PERF_EN.
module fusion_seq_ctrl
    import fusion_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = $clog2(NUM_BANKS),
    parameter int MODE_WIDTH = $clog2(ADDR_WIDTH + 1),
    parameter int MAX_MODE   = ADDR_WIDTH + 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [MODE_WIDTH-1:0] cfg_mode,
    input  logic [CNT_WIDTH-1:0]  cfg_num_ops,
    output logic [MODE_WIDTH-1:0] precision_mode,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  step_valid,
    input  logic                  step_ready,
    output logic                  step_first,
    output logic                  step_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
`ifdef FUSION_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_step_cnt
`endif
);

    state_t                state, state_nxt;
    logic                  accept, reject, fire, wrap, last_op;
    logic                  pass_first, pass_last_flag;
    logic [CNT_WIDTH-1:0]  num_ops_q, op_cnt;
    logic [ADDR_WIDTH-1:0] limit;

    assign step_valid = (state == RUN);
    assign fire       = step_valid & step_ready;
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);
    // Held low while reset is asserted so nothing is accepted mid-reset.
    assign cfg_ready  = (state == IDLE) & reset;
    assign last_op    = (op_cnt == num_ops_q - CNT_WIDTH'(1));
    assign limit      = ADDR_WIDTH'(pass_last(NUM_BANKS, int'(precision_mode)));
    assign step_first = step_valid & pass_first;
    assign step_last  = step_valid & pass_last_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    if (mode_legal(int'(cfg_mode), MAX_MODE)) begin
                        accept    = 1'b1;
                        state_nxt = (cfg_num_ops != '0) ? RUN : DONE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN:     if (wrap && last_op) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            precision_mode <= '0;
            num_ops_q      <= '0;
            op_cnt         <= '0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                precision_mode <= cfg_mode;
                num_ops_q      <= cfg_num_ops;
                op_cnt         <= '0;
            end else if (wrap) begin
                op_cnt <= op_cnt + CNT_WIDTH'(1);
            end
        end
    end

    fusion_pass_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (fire),
        .limit (limit),
        .addr  (addr),
        .first (pass_first),
        .last  (pass_last_flag),
        .wrap  (wrap)
    );

`ifdef FUSION_SEQ_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_step_cnt  <= '0;
        end else if (accept) begin
            perf_stall_cnt <= '0;
            perf_step_cnt  <= '0;
        end else begin
            if (step_valid && !step_ready) perf_stall_cnt <= sat_inc(perf_stall_cnt);
            if (fire)                      perf_step_cnt  <= sat_inc(perf_step_cnt);
        end
    end
`endif

endmodule
